// File: rtl/gsm_pkg.sv
// Shared constants for the GSM modem response parser: control characters,
// response keywords and parser states.
package gsm_pkg;

    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_GT    = 8'h3E;
    localparam logic [7:0] CHAR_SP    = 8'h20;
    localparam logic [7:0] CHAR_COMMA = 8'h2C;

    // Keywords are right-aligned: byte 0 of a keyword sits at index LEN-1.
    localparam int KW_MAX = 10;
    typedef logic [KW_MAX-1:0][7:0] kw_t;

    localparam kw_t KW_OK     = 80'("OK");
    localparam kw_t KW_ERROR  = 80'("ERROR");
    localparam kw_t KW_CMS    = 80'("+CMS ERROR");
    localparam kw_t KW_CME    = 80'("+CME ERROR");
    localparam kw_t KW_CMTI   = 80'("+CMTI:");
    localparam kw_t KW_PROMPT = 80'("> ");

    localparam int KW_OK_LEN     = 2;
    localparam int KW_ERROR_LEN  = 5;
    localparam int KW_CMS_LEN    = 10;
    localparam int KW_CME_LEN    = 10;
    localparam int KW_CMTI_LEN   = 6;
    localparam int KW_PROMPT_LEN = 2;

    localparam logic [0:0] LINE = 1'b0;
    localparam logic [0:0] SKIP = 1'b1;

    // A candidate survives once its keyword is fully matched.
    function automatic logic kw_keep(input kw_t kw, input int len, input int p,
                                     input logic [7:0] b);
        if (p >= len) return 1'b1;
        return kw[4'(len - 1 - p)] == b;
    endfunction

endpackage

// File: rtl/gsm_resp_timer.sv
// Response timeout: arm loads a down-counter, a final response or expiry
// ends the wait. Arm always wins over done and expiry.
module gsm_resp_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic arm,
    input  logic done,
    output logic busy,
    output logic timeout
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (arm) begin
                cnt  <= CNT_LOAD;
                busy <= 1'b1;
            end else if (busy) begin
                if (done) begin
                    busy <= 1'b0;
                end else if (cnt == '0) begin
                    timeout <= 1'b1;
                    busy    <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gsm_rx_parser.sv
// Streaming classifier for GSM modem response lines with a per-command
// response timeout.
//
//   state | meaning
//   LINE  | matching bytes of the current line against all keywords
//   SKIP  | line overflowed; discard bytes up to the next LF
module gsm_rx_parser
    import gsm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned LINE_MAX       = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    input  logic       arm,
    output logic       busy,
    output logic       resp_ok,
    output logic       resp_error,
    output logic       resp_prompt,
    output logic       resp_timeout,
    output logic       sms_new,
    output logic [7:0] sms_index,
    output logic       overflow
);
    localparam int PW = $clog2(LINE_MAX + 1);
    localparam logic [PW-1:0] POS_MAX  = PW'(LINE_MAX);
    localparam logic [PW-1:0] POS_OK   = PW'(KW_OK_LEN);
    localparam logic [PW-1:0] POS_ERR  = PW'(KW_ERROR_LEN);
    localparam logic [PW-1:0] POS_CMX  = PW'(KW_CMS_LEN);
    localparam logic [PW-1:0] POS_CMTI = PW'(KW_CMTI_LEN);

    logic [0:0]    state;
    logic [PW-1:0] pos;
    logic          c_ok, c_err, c_cms, c_cme, c_cmti, c_prm;
    logic [7:0]    acc;
    logic          dig, comma;

    logic        is_cr, is_lf, is_dig, line_end, data_byte, restart;
    logic        ok_n, err_n, sms_n, prm_n, ovf_n;
    logic [11:0] prod;
    logic [7:0]  acc_next;

    always_comb begin
        is_cr     = rx_data == CHAR_CR;
        is_lf     = rx_data == CHAR_LF;
        is_dig    = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        line_end  = rx_done && is_lf && (state == LINE) && (pos != '0);
        data_byte = rx_done && !is_cr && !is_lf && (state == LINE);
        ok_n      = line_end && c_ok && (pos == POS_OK);
        err_n     = line_end && !ok_n &&
                    ((c_err && (pos == POS_ERR)) || ((c_cms || c_cme) && (pos >= POS_CMX)));
        sms_n     = line_end && !ok_n && !err_n && c_cmti && (pos >= POS_CMTI) && comma && dig;
        ovf_n     = data_byte && (pos == POS_MAX);
        prm_n     = data_byte && !ovf_n && c_prm && (pos == PW'(1)) && (rx_data == CHAR_SP);
        restart   = (rx_done && is_lf) || prm_n;
        prod      = 12'(acc) * 12'd10 + 12'(rx_data[3:0]);
        acc_next  = (prod > 12'd255) ? 8'hFF : prod[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LINE;
            pos         <= '0;
            {c_ok, c_err, c_cms, c_cme, c_cmti, c_prm} <= '1;
            acc         <= '0;
            dig         <= 1'b0;
            comma       <= 1'b0;
            resp_ok     <= 1'b0;
            resp_error  <= 1'b0;
            resp_prompt <= 1'b0;
            sms_new     <= 1'b0;
            sms_index   <= '0;
            overflow    <= 1'b0;
        end else begin
            resp_ok     <= ok_n;
            resp_error  <= err_n;
            resp_prompt <= prm_n;
            sms_new     <= sms_n;
            overflow    <= ovf_n;
            if (sms_n) sms_index <= acc;

            if (restart) begin
                state <= LINE;
                pos   <= '0;
                {c_ok, c_err, c_cms, c_cme, c_cmti, c_prm} <= '1;
                acc   <= '0;
                dig   <= 1'b0;
                comma <= 1'b0;
            end else if (ovf_n) begin
                state <= SKIP;
            end else if (data_byte) begin
                c_ok   <= c_ok   && kw_keep(KW_OK,     KW_OK_LEN,     int'(pos), rx_data);
                c_err  <= c_err  && kw_keep(KW_ERROR,  KW_ERROR_LEN,  int'(pos), rx_data);
                c_cms  <= c_cms  && kw_keep(KW_CMS,    KW_CMS_LEN,    int'(pos), rx_data);
                c_cme  <= c_cme  && kw_keep(KW_CME,    KW_CME_LEN,    int'(pos), rx_data);
                c_cmti <= c_cmti && kw_keep(KW_CMTI,   KW_CMTI_LEN,   int'(pos), rx_data);
                c_prm  <= c_prm  && kw_keep(KW_PROMPT, KW_PROMPT_LEN, int'(pos), rx_data);
                pos    <= pos + 1'b1;
                // Index digits only count past the "+CMTI:" prefix.
                if (pos >= POS_CMTI) begin
                    if (rx_data == CHAR_COMMA) begin
                        acc   <= '0;
                        dig   <= 1'b0;
                        comma <= 1'b1;
                    end else if (is_dig) begin
                        acc <= acc_next;
                        dig <= 1'b1;
                    end
                end
            end
        end
    end

    gsm_resp_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .arm    (arm),
        .done   (ok_n || err_n || prm_n),
        .busy   (busy),
        .timeout(resp_timeout)
    );

endmodule

// File: tb/tb_gsm_rx_parser.sv
// Bench for gsm_rx_parser: directed scenarios plus random modem traffic,
// compared cycle by cycle against a line-buffer reference model.
module tb_gsm_rx_parser;
    localparam int TMO  = 100;
    localparam int LMAX = 32;

    logic       clk = 1'b0;
    logic       rst, rx_done, arm;
    logic [7:0] rx_data;
    logic       busy, resp_ok, resp_error, resp_prompt, resp_timeout, sms_new, overflow;
    logic [7:0] sms_index;

    gsm_rx_parser #(.TIMEOUT_CYCLES(TMO), .LINE_MAX(LMAX)) dut (
        .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data), .arm(arm),
        .busy(busy), .resp_ok(resp_ok), .resp_error(resp_error),
        .resp_prompt(resp_prompt), .resp_timeout(resp_timeout), .sms_new(sms_new),
        .sms_index(sms_index), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: buffered line text, classified when the line ends.
    logic [7:0] mline[$];
    bit         mskip, mbusy;
    int         mdead, edge_n;
    logic [7:0] midx;
    logic       e_ok, e_err, e_prm, e_sms, e_ovf, e_tmo, e_busy;
    int         n_ok, n_err, n_prm, n_sms, n_ovf, n_tmo;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic bit starts(input string k);
        if (mline.size() < k.len()) return 1'b0;
        for (int i = 0; i < k.len(); i++)
            if (mline[i] != k[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic classify();
        int last, v;
        bit seen;
        if (mline.size() == 2 && starts("OK")) e_ok = 1'b1;
        else if (mline.size() == 5 && starts("ERROR")) e_err = 1'b1;
        else if (starts("+CMS ERROR") || starts("+CME ERROR")) e_err = 1'b1;
        else if (starts("+CMTI:")) begin
            last = -1;
            for (int i = 6; i < mline.size(); i++)
                if (mline[i] == 8'h2C) last = i;
            if (last >= 0) begin
                v = 0;
                seen = 1'b0;
                for (int i = last + 1; i < mline.size(); i++)
                    if (mline[i] >= 8'h30 && mline[i] <= 8'h39) begin
                        v = v * 10 + int'(mline[i] - 8'h30);
                        if (v > 255) v = 255;
                        seen = 1'b1;
                    end
                if (seen) begin
                    e_sms = 1'b1;
                    midx  = 8'(v);
                end
            end
        end
    endtask

    task automatic model(input bit r, input bit v, input logic [7:0] d, input bit a);
        {e_ok, e_err, e_prm, e_sms, e_ovf, e_tmo} = '0;
        edge_n++;
        if (r) begin
            mline.delete();
            mskip = 1'b0;
            mbusy = 1'b0;
            midx  = 8'd0;
        end else begin
            if (v) begin
                if (d == 8'h0D) begin
                end else if (d == 8'h0A) begin
                    if (!mskip && mline.size() > 0) classify();
                    mline.delete();
                    mskip = 1'b0;
                end else if (mskip) begin
                end else if (mline.size() == LMAX) begin
                    e_ovf = 1'b1;
                    mskip = 1'b1;
                end else begin
                    mline.push_back(d);
                    if (mline.size() == 2 && mline[0] == 8'h3E && mline[1] == 8'h20) begin
                        e_prm = 1'b1;
                        mline.delete();
                    end
                end
            end
            if (a) begin
                mbusy = 1'b1;
                mdead = edge_n + TMO + 1;
            end else if (mbusy && (e_ok || e_err || e_prm)) begin
                mbusy = 1'b0;
            end else if (mbusy && edge_n == mdead) begin
                e_tmo = 1'b1;
                mbusy = 1'b0;
            end
        end
        e_busy = mbusy;
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] d, input bit a);
        @(negedge clk);
        rst = r; rx_done = v; rx_data = d; arm = a;
        model(r, v, d, a);
        @(posedge clk);
        #1;
        chk("resp_ok", resp_ok, e_ok);
        chk("resp_error", resp_error, e_err);
        chk("resp_prompt", resp_prompt, e_prm);
        chk("sms_new", sms_new, e_sms);
        chk("sms_index", sms_index, midx);
        chk("overflow", overflow, e_ovf);
        chk("resp_timeout", resp_timeout, e_tmo);
        chk("busy", busy, e_busy);
        n_ok += int'(resp_ok); n_err += int'(resp_error); n_prm += int'(resp_prompt);
        n_sms += int'(sms_new); n_ovf += int'(overflow); n_tmo += int'(resp_timeout);
    endtask

    task automatic send_raw(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b0, 1'b1, s[i], 1'b0);
    endtask

    task automatic send_line(input string s);
        send_raw(s);
        step(1'b0, 1'b1, 8'h0D, 1'b0);
        step(1'b0, 1'b1, 8'h0A, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Arm, optionally re-arm at a given cycle, and return the cycle of resp_timeout.
    task automatic arm_seq(input int rearm_at, output int k);
        k = -1;
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 400; i++) begin
            step(1'b0, 1'b0, 8'h00, i == rearm_at);
            if (resp_timeout === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic rnd_byte(input logic [7:0] b);
        int gap;
        gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) step(1'b0, 1'b0, 8'h00, $urandom_range(0, 24) == 0);
        if ($urandom_range(0, 7) == 0) step(1'b0, 1'b1, 8'h0D, 1'b0);
        step(1'b0, 1'b1, b, $urandom_range(0, 24) == 0);
    endtask

    string table_s[$] = '{"OK", "ERROR", "ERRORX", "+CMS ERROR: 5", "+CME ERROR: 10",
                          "+CMTI: \"SM\",7", "+CMTI: \"ME\",300", "+CMTI: \"SM\",",
                          "AT+CMGF=1", "+CSQ: 20,0", "OK!", "> ", "", "+CMTI:5", "ERR"};
    string alpha = "OKER+CMSTI:, >0123456789A\"";

    initial begin
        int k, b0;
        logic [7:0] q[$];
        rst = 1'b1; rx_done = 1'b0; arm = 1'b0; rx_data = 8'h00;
        edge_n = 0; mbusy = 1'b0; mskip = 1'b0; midx = 8'd0;
        {n_ok, n_err, n_prm, n_sms, n_ovf, n_tmo} = '0;

        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Echo line, blank line, then OK while armed.
        step(1'b0, 1'b0, 8'h00, 1'b1);
        send_line("AT");
        chk("echo_silent", n_ok + n_err + n_prm + n_sms, 0);
        step(1'b0, 1'b1, 8'h0D, 1'b0);
        step(1'b0, 1'b1, 8'h0A, 1'b0);
        send_line("OK");
        chk("ok_count", n_ok, 1);
        chk("ok_busy_cleared", busy, 0);

        send_line("+CMTI: \"SM\",12");
        chk("cmti_index12", sms_index, 12);
        send_line("+CMTI: \"SM\",999");
        chk("cmti_saturate", sms_index, 255);
        chk("cmti_count", n_sms, 2);

        send_line("+CMS ERROR: 500");
        chk("cms_error", n_err, 1);
        send_line("ERRORX");
        chk("errorx_silent", n_err, 1);

        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h3E, 1'b0);
        step(1'b0, 1'b1, 8'h20, 1'b0);
        chk("prompt_now", resp_prompt, 1);
        chk("prompt_busy_cleared", busy, 0);

        arm_seq(0, k);
        chk("timeout_101", k, 101);
        arm_seq(50, k);
        chk("timeout_rearm_151", k, 151);
        arm_seq(101, k);
        chk("timeout_arm_at_expiry", k, 202);

        // Arm coincident with a final response keeps the wait alive.
        send_raw("OK");
        step(1'b0, 1'b1, 8'h0A, 1'b1);
        chk("arm_wins_ok", resp_ok, 1);
        chk("arm_wins_busy", busy, 1);
        send_line("ERROR");

        b0 = n_ovf;
        for (int i = 0; i < LMAX + 8; i++) step(1'b0, 1'b1, 8'h41, 1'b0);
        send_line("");
        chk("overflow_once", n_ovf - b0, 1);
        b0 = n_ok;
        send_line("OK");
        chk("ok_after_overflow", n_ok - b0, 1);

        b0 = n_ok;
        step(1'b0, 1'b1, 8'h4F, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        send_line("K");
        chk("reset_midline", n_ok - b0, 0);

        for (int it = 0; it < 250; it++) begin
            q.delete();
            if ($urandom_range(0, 9) == 0) begin
                int len = $urandom_range(25, 40);
                for (int i = 0; i < len; i++) q.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
            end else begin
                string s = table_s[$urandom_range(0, table_s.size() - 1)];
                for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
                if (q.size() > 0 && $urandom_range(0, 3) == 0)
                    q[$urandom_range(0, q.size() - 1)] = alpha[$urandom_range(0, alpha.len() - 1)];
            end
            foreach (q[i]) rnd_byte(q[i]);
            if ($urandom_range(0, 5) != 0) begin
                rnd_byte(8'h0D);
                rnd_byte(8'h0A);
            end
            if ($urandom_range(0, 49) == 0) step(1'b1, 1'b0, 8'h00, 1'b0);
        end
        idle(TMO + 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
